// File: rtl/video_timing_pkg.sv
// Shared raster-mode description and helpers for the starsoc video blocks.
// Colour constants live in starsoc_params, not here.
package video_timing_pkg;

    typedef struct packed {
        int   h_visible;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_visible;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic h_pol;
        logic v_pol;
    } mode_t;

    localparam mode_t MODE_640x480_60 = '{
        h_visible: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_visible: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    function automatic int h_total(input mode_t m);
        return m.h_visible + m.h_fp + m.h_sync + m.h_bp;
    endfunction

    function automatic int v_total(input mode_t m);
        return m.v_visible + m.v_fp + m.v_sync + m.v_bp;
    endfunction

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: one-cycle tick every CLK_DIV cycles while enable is high.
// Reusable by any block that runs at pixel rate off the system clock.
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    // CLK_DIV=1 degenerates to a counter stuck at zero, so tick follows enable.
    localparam int              DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        div_d = div_q;
        if (!enable || div_q == LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = enable && (div_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data-enable, coordinates and
// line/frame strobes, registered one clock after each pixel tick.
module vga_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_VISIBLE  = MODE_640x480_60.h_visible,
    parameter int H_FP       = MODE_640x480_60.h_fp,
    parameter int H_SYNC     = MODE_640x480_60.h_sync,
    parameter int H_BP       = MODE_640x480_60.h_bp,
    parameter int V_VISIBLE  = MODE_640x480_60.v_visible,
    parameter int V_FP       = MODE_640x480_60.v_fp,
    parameter int V_SYNC     = MODE_640x480_60.v_sync,
    parameter int V_BP       = MODE_640x480_60.v_bp,
    parameter bit H_SYNC_POL = MODE_640x480_60.h_pol,
    parameter bit V_SYNC_POL = MODE_640x480_60.v_pol,
    parameter int CLK_DIV    = 4,
    parameter int CW         = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic          pix_valid,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam mode_t MODE = '{
        h_visible: H_VISIBLE, h_fp: H_FP, h_sync: H_SYNC, h_bp: H_BP,
        v_visible: V_VISIBLE, v_fp: V_FP, v_sync: V_SYNC, v_bp: V_BP,
        h_pol: H_SYNC_POL, v_pol: V_SYNC_POL
    };

    localparam logic [CW-1:0] H_LAST   = CW'(h_total(MODE) - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(v_total(MODE) - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FP);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_VISIBLE + V_FP);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic          H_IDLE   = ~H_SYNC_POL;
    localparam logic          V_IDLE   = ~V_SYNC_POL;

    logic tick;

    clk_en_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (tick)
    );

    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (!enable) begin
            hc_d = '0;
            vc_d = '0;
        end else if (tick) begin
            if (hc_q == H_LAST) begin
                hc_d = '0;
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
            end else begin
                hc_d = hc_q + CW'(1);
            end
        end
    end

    logic          pix_valid_q, hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
    logic          pix_valid_d, hsync_d, vsync_d, de_d, line_start_d, frame_start_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;

    // Decode the pre-increment position; strobes pulse only alongside pix_valid.
    always_comb begin
        pix_valid_d   = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        x_d           = x_q;
        y_d           = y_q;
        if (!enable) begin
            hsync_d = H_IDLE;
            vsync_d = V_IDLE;
            de_d    = 1'b0;
            x_d     = '0;
            y_d     = '0;
        end else if (tick) begin
            pix_valid_d   = 1'b1;
            x_d           = hc_q;
            y_d           = vc_q;
            de_d          = (hc_q < H_VIS) && (vc_q < V_VIS);
            hsync_d       = (hc_q >= HS_FIRST && hc_q <= HS_LAST) ? H_SYNC_POL : H_IDLE;
            vsync_d       = (vc_q >= VS_FIRST && vc_q <= VS_LAST) ? V_SYNC_POL : V_IDLE;
            line_start_d  = (hc_q == '0);
            frame_start_d = (hc_q == '0) && (vc_q == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hc_q          <= '0;
            vc_q          <= '0;
            pix_valid_q   <= 1'b0;
            hsync_q       <= H_IDLE;
            vsync_q       <= V_IDLE;
            de_q          <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            pix_valid_q   <= pix_valid_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pix_valid   = pix_valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: three instances (two small modes, one default)
// compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int CW = 11;

    typedef struct {
        int hv, hfp, hsw, hbp, vv, vfp, vsw, vbp;
        bit hp, vp;
        int d;
    } cfg_t;

    typedef struct {
        logic pv, hs, vs, de, ls, fs;
        int   x, y;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    logic enable;

    always #5 clk = ~clk;

    logic          pv_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic          pv_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic          pv_c, hs_c, vs_c, de_c, ls_c, fs_c;
    logic [CW-1:0] x_a, y_a, x_b, y_b, x_c, y_c;

    vga_timing_gen #(
        .H_VISIBLE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .CLK_DIV(3), .CW(CW)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .pix_valid(pv_a), .hsync(hs_a),
        .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CLK_DIV(1), .CW(CW)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .pix_valid(pv_b), .hsync(hs_b),
        .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen dut_c (
        .clk(clk), .rst(rst), .enable(enable), .pix_valid(pv_c), .hsync(hs_c),
        .vsync(vs_c), .de(de_c), .x(x_c), .y(y_c), .line_start(ls_c), .frame_start(fs_c)
    );

    function automatic cfg_t get_cfg(input int id);
        cfg_t c;
        case (id)
            0:       c = '{10, 2, 3, 4, 6, 1, 2, 3, 1'b0, 1'b0, 3};
            1:       c = '{6, 1, 2, 1, 4, 1, 1, 2, 1'b1, 1'b1, 1};
            default: c = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 4};
        endcase
        return c;
    endfunction

    // k = clock edges seen with enable high since the last reset or enable-low edge.
    int k = 0;
    always @(posedge clk or posedge rst) begin
        if (rst || !enable) k <= 0;
        else                k <= k + 1;
    end

    // After k enabled edges, floor(k/d) pixels have been presented; the last one is held.
    function automatic obs_t model(input cfg_t c, input int kk);
        obs_t o;
        int   ht, vt, p, hs0, vs0;
        ht   = c.hv + c.hfp + c.hsw + c.hbp;
        vt   = c.vv + c.vfp + c.vsw + c.vbp;
        o.pv = 1'b0; o.de = 1'b0; o.ls = 1'b0; o.fs = 1'b0;
        o.x  = 0;    o.y  = 0;    o.hs = ~c.hp; o.vs = ~c.vp;
        if (kk >= c.d) begin
            p    = kk / c.d - 1;
            o.pv = (kk % c.d) == 0;
            o.x  = p % ht;
            o.y  = (p / ht) % vt;
            hs0  = c.hv + c.hfp;
            vs0  = c.vv + c.vfp;
            o.de = (o.x < c.hv) && (o.y < c.vv);
            o.hs = (o.x >= hs0 && o.x < hs0 + c.hsw) ? c.hp : ~c.hp;
            o.vs = (o.y >= vs0 && o.y < vs0 + c.vsw) ? c.vp : ~c.vp;
            o.ls = o.pv && (o.x == 0);
            o.fs = o.ls && (o.y == 0);
        end
        return o;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, k=%0d)", tag, got, exp, $time, k);
        end
    endtask

    int n_strobe[3], n_de[3], n_ls[3], n_clk[3], n_frames[3];
    bit armed[3];

    task automatic sample(input int id, input string nm, input logic pv, input logic hs,
                          input logic vs, input logic de, input logic [CW-1:0] xx,
                          input logic [CW-1:0] yy, input logic ls, input logic fs);
        cfg_t c;
        obs_t e;
        int   ht, vt;
        c  = get_cfg(id);
        e  = model(c, k);
        ht = c.hv + c.hfp + c.hsw + c.hbp;
        vt = c.vv + c.vfp + c.vsw + c.vbp;
        check({nm, ".pix_valid"},   32'(pv), 32'(e.pv));
        check({nm, ".hsync"},       32'(hs), 32'(e.hs));
        check({nm, ".vsync"},       32'(vs), 32'(e.vs));
        check({nm, ".de"},          32'(de), 32'(e.de));
        check({nm, ".x"},           32'(xx), 32'(e.x));
        check({nm, ".y"},           32'(yy), 32'(e.y));
        check({nm, ".line_start"},  32'(ls), 32'(e.ls));
        check({nm, ".frame_start"}, 32'(fs), 32'(e.fs));
        // Whole-frame statistics, only across undisturbed frames.
        if (k == 0) armed[id] = 1'b0;
        n_clk[id]++;
        if (pv === 1'b1) begin
            if (fs === 1'b1) begin
                if (armed[id]) begin
                    check({nm, ".frame_strobes"}, n_strobe[id], ht * vt);
                    check({nm, ".frame_de"},      n_de[id],     c.hv * c.vv);
                    check({nm, ".frame_lines"},   n_ls[id],     vt);
                    check({nm, ".frame_period"},  n_clk[id],    ht * vt * c.d);
                    n_frames[id]++;
                end
                armed[id]    = 1'b1;
                n_strobe[id] = 0;
                n_de[id]     = 0;
                n_ls[id]     = 0;
                n_clk[id]    = 0;
            end
            n_strobe[id]++;
            if (de === 1'b1) n_de[id]++;
            if (ls === 1'b1) n_ls[id]++;
        end
    endtask

    always @(negedge clk) begin
        sample(0, "a", pv_a, hs_a, vs_a, de_a, x_a, y_a, ls_a, fs_a);
        sample(1, "b", pv_b, hs_b, vs_b, de_b, x_b, y_b, ls_b, fs_b);
        sample(2, "c", pv_c, hs_c, vs_c, de_c, x_c, y_c, ls_c, fs_c);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Wait (bounded) until instance a presents the given pixel.
    task automatic wait_a(input int wx, input int wy, output bit found);
        found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            step(1);
            found = (pv_a === 1'b1) && (x_a == CW'(wx)) && (y_a == CW'(wy));
        end
    endtask

    bit found;

    initial begin
        rst    = 1'b0;
        enable = 1'b1;
        #1 rst = 1'b1;
        step(3);
        rst = 1'b0;

        // Several undisturbed frames of instance a (684 clks each).
        step(2200);

        // Enable dropped mid-frame for 10 clks, then raised.
        wait_a(5, 3, found);
        check("a.wait_5_3", 32'(found), 32'd1);
        enable = 1'b0;
        step(10);
        enable = 1'b1;
        step(300);

        // One-cycle reset mid-line.
        wait_a(7, 2, found);
        check("a.wait_7_2", 32'(found), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(300);

        // Random disturbances.
        for (int i = 0; i < 30; i++) begin
            step($urandom_range(1, 250));
            case ($urandom_range(0, 3))
                0: begin
                    enable = 1'b0;
                    step($urandom_range(1, 12));
                    enable = 1'b1;
                end
                1: begin
                    rst    = 1'b1;
                    enable = 1'($urandom_range(0, 1));
                    step($urandom_range(1, 3));
                    rst    = 1'b0;
                    enable = 1'b1;
                end
                default: ;
            endcase
        end

        // Clean tail so full frames are exercised after the random phase.
        step(1500);

        check("a.frames_checked", 32'(n_frames[0] >= 4), 32'd1);
        check("b.frames_checked", 32'(n_frames[1] >= 20), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
